// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA output stage: fade states, level and colour widths.
// Latency: none (declarations only); no backpressure.
package vga_pkg;

    localparam int LEVEL_MAX = 16;
    localparam int LEVEL_W   = 5;
    localparam int COLOR_W   = 4;

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        STEADY   = 2'd1,
        FADE_OUT = 2'd2,
        DARK     = 2'd3
    } fade_state_t;

    // Level 16 is unity gain: c*16 >> 4 == c. Bit 8 saturates to full scale.
    function automatic logic [COLOR_W-1:0] scale_color(
        input logic [COLOR_W-1:0] c,
        input logic [LEVEL_W-1:0] lvl
    );
        logic [COLOR_W+LEVEL_W-1:0] p;
        p = {{LEVEL_W{1'b0}}, c} * {{COLOR_W{1'b0}}, lvl};
        return p[COLOR_W+LEVEL_W-1] ? {COLOR_W{1'b1}} : COLOR_W'(p >> COLOR_W);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Registered shift line with synchronous reset; every stage is exposed on taps.
// Latency: DEPTH cycles to taps[DEPTH-1]; no backpressure, shifts every cycle.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    logic [DEPTH-1:0][WIDTH-1:0] line_q;
    logic [DEPTH-1:0][WIDTH-1:0] line_d;

    always_comb begin
        line_d    = line_q;
        line_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            line_d[i] = line_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= {DEPTH{RESET_VAL}};
        end else begin
            line_q <= line_d;
        end
    end

    assign taps = line_q;

endmodule

// File: rtl/vga_output_stage.sv
// Final pixel stage: frame-paced brightness fade, blanking, and sync delayed to match colour.
// Latency: rgb 2 cycles, sync COLOR_LATENCY+2 cycles; no backpressure, one pixel per clock.
module vga_output_stage
    import vga_pkg::*;
#(
    parameter int   COLOR_LATENCY = 0,
    parameter int   FADE_FRAMES   = 4,
    parameter logic SYNC_IDLE     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hsync_i,
    input  logic                vsync_i,
    input  logic                visible_i,
    input  logic [31:0]         frame_i,
    input  logic [COLOR_W-1:0]  r_i,
    input  logic [COLOR_W-1:0]  g_i,
    input  logic [COLOR_W-1:0]  b_i,
    input  logic                fade_out_i,
    input  logic                fade_in_i,
    output logic                hsync,
    output logic                vsync,
    output logic [COLOR_W-1:0]  r,
    output logic [COLOR_W-1:0]  g,
    output logic [COLOR_W-1:0]  b,
    output logic [LEVEL_W-1:0]  level
);

    localparam int                  DEPTH     = COLOR_LATENCY + 2;
    localparam int                  STEP_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(FADE_FRAMES - 1);
    localparam logic [LEVEL_W-1:0]  LVL_MAX   = LEVEL_W'(LEVEL_MAX);
    localparam logic [2:0]          LINE_RST  = {SYNC_IDLE, SYNC_IDLE, 1'b0};

    logic [31:0]        frame_prev_q, frame_prev_d;
    fade_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               tick;

    logic [COLOR_W-1:0] r_s1_q, g_s1_q, b_s1_q;
    logic [COLOR_W-1:0] r_s1_d, g_s1_d, b_s1_d;
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic [COLOR_W-1:0] r_d, g_d, b_d;

    logic [DEPTH-1:0][2:0] taps;
    logic                  vis_dly;
    logic                  unused_taps;

    assign tick = (frame_i != frame_prev_q) && !rst;

    // Pulses take priority over a tick in the same cycle, so that tick is dropped.
    always_comb begin
        frame_prev_d = frame_i;
        state_d      = state_q;
        level_d      = level_q;
        step_d       = step_q;
        if (fade_in_i) begin
            state_d = FADE_IN;
            level_d = '0;
            step_d  = '0;
        end else if (fade_out_i && (state_q != DARK)) begin
            state_d = FADE_OUT;
            step_d  = '0;
        end else begin
            case (state_q)
                FADE_IN: begin
                    if (level_q >= LVL_MAX) begin
                        state_d = STEADY;
                    end else if (tick) begin
                        if (step_q == STEP_LAST) begin
                            step_d  = '0;
                            level_d = level_q + 1'b1;
                            if (level_d == LVL_MAX) state_d = STEADY;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (level_q == '0) begin
                        state_d = DARK;
                    end else if (tick) begin
                        if (step_q == STEP_LAST) begin
                            step_d  = '0;
                            level_d = level_q - 1'b1;
                            if (level_d == '0) state_d = DARK;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Scale with the level that applies after this edge so a frame's first pixel gets its level.
    assign vis_dly     = taps[COLOR_LATENCY][0];
    assign unused_taps = ^taps;

    always_comb begin
        r_s1_d = scale_color(r_i, level_d);
        g_s1_d = scale_color(g_i, level_d);
        b_s1_d = scale_color(b_i, level_d);
        r_d    = vis_dly ? r_s1_q : '0;
        g_d    = vis_dly ? g_s1_q : '0;
        b_d    = vis_dly ? b_s1_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FADE_IN;
            level_q <= '0;
            step_q  <= '0;
            r_s1_q  <= '0;
            g_s1_q  <= '0;
            b_s1_q  <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            step_q  <= step_d;
            r_s1_q  <= r_s1_d;
            g_s1_q  <= g_s1_d;
            b_s1_q  <= b_s1_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
        frame_prev_q <= frame_prev_d;
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (DEPTH),
        .RESET_VAL (LINE_RST)
    ) u_sync_line (
        .clk  (clk),
        .rst  (rst),
        .din  ({hsync_i, vsync_i, visible_i}),
        .taps (taps)
    );

    assign hsync = taps[DEPTH-1][2];
    assign vsync = taps[DEPTH-1][1];
    assign r     = r_q;
    assign g     = g_q;
    assign b     = b_q;
    assign level = level_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage: two instances (colour lag 0 and 3) fed in parallel.
// Expected pixels are queued at drive time and compared when due; levels follow n/FADE_FRAMES.
module tb_vga_output_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_i, vsync_i, visible_i;
    logic [31:0] frame_i;
    logic [3:0]  r_i, g_i, b_i;
    logic        fade_out_i, fade_in_i;

    logic        hsync0, vsync0, hsync3, vsync3;
    logic [3:0]  r0, g0, b0, r3, g3, b3;
    logic [4:0]  level0, level3;

    always #5 clk = ~clk;

    vga_output_stage #(.COLOR_LATENCY(0), .FADE_FRAMES(4), .SYNC_IDLE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i), .visible_i(visible_i),
        .frame_i(frame_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .fade_out_i(fade_out_i), .fade_in_i(fade_in_i),
        .hsync(hsync0), .vsync(vsync0), .r(r0), .g(g0), .b(b0), .level(level0)
    );

    vga_output_stage #(.COLOR_LATENCY(3), .FADE_FRAMES(4), .SYNC_IDLE(1'b1)) dut3 (
        .clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i), .visible_i(visible_i),
        .frame_i(frame_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .fade_out_i(fade_out_i), .fade_in_i(fade_in_i),
        .hsync(hsync3), .vsync(vsync3), .r(r3), .g(g3), .b(b3), .level(level3)
    );

    typedef struct {
        int          due;
        logic [13:0] exp;
    } sb_t;

    typedef struct {
        logic       hs, vs, vis;
        logic [3:0] r, g, b;
        logic [3:0] er, eg, eb;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    sb_t        q0[$];
    sb_t        q3[$];
    logic [2:0] hist[$];
    logic [4:0] lvl_pend;
    bit         lvl_chk = 1'b0;
    vec_t       vecs[7];

    function automatic logic [3:0] scale_ref(input logic [3:0] c, input int lvl);
        int v;
        v = (int'(c) * lvl) / 16;
        if (v > 15) v = 15;
        return 4'(v);
    endfunction

    function automatic logic [11:0] pix_ref(input logic vis, input logic [3:0] cr,
                                            input logic [3:0] cg, input logic [3:0] cb,
                                            input int lvl);
        return vis ? {scale_ref(cr, lvl), scale_ref(cg, lvl), scale_ref(cb, lvl)} : 12'h000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (lvl_chk) begin
            check("level0", 32'(level0), 32'(lvl_pend));
            check("level3", 32'(level3), 32'(lvl_pend));
            lvl_chk = 1'b0;
        end
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            sb_t e;
            e = q0.pop_front();
            check("pix_lat0", 32'({hsync0, vsync0, r0, g0, b0}), 32'(e.exp));
        end
        while (q3.size() > 0 && q3[0].due <= cyc) begin
            sb_t e;
            e = q3.pop_front();
            check("pix_lat3", 32'({hsync3, vsync3, r3, g3, b3}), 32'(e.exp));
        end
    endtask

    // e0 is the lag-0 colour; the lag-3 model pairs this rgb with sync/visible from 3 drives ago.
    task automatic drive(input logic hs, input logic vs, input logic vis,
                         input logic [3:0] cr, input logic [3:0] cg, input logic [3:0] cb,
                         input bit inc, input bit fo, input bit fi,
                         input int lvl, input logic [11:0] e0);
        sb_t        e;
        logic [2:0] old;
        hsync_i    = hs;
        vsync_i    = vs;
        visible_i  = vis;
        r_i        = cr;
        g_i        = cg;
        b_i        = cb;
        fade_out_i = fo;
        fade_in_i  = fi;
        if (inc) frame_i = frame_i + 32'd1;
        e.due = cyc + 2;
        e.exp = {hs, vs, e0};
        q0.push_back(e);
        old   = hist.pop_front();
        e.exp = {old[2], old[1], pix_ref(old[0], cr, cg, cb, lvl)};
        q3.push_back(e);
        hist.push_back({hs, vs, vis});
        lvl_pend = 5'(lvl);
        lvl_chk  = 1'b1;
        clk_cycle();
    endtask

    task automatic ticks(input int n0, input int n1, input bit down);
        for (int n = n0; n <= n1; n++) begin
            int lvl;
            lvl = down ? 16 - n / 4 : n / 4;
            if (lvl < 0) lvl = 0;
            if (lvl > 16) lvl = 16;
            drive(1'(n % 5 != 0), 1'(n % 7 != 0), 1'b1, 4'hF, 4'hA, 4'h3,
                  1'b1, 1'b0, 1'b0, lvl, pix_ref(1'b1, 4'hF, 4'hA, 4'h3, lvl));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 4'hF, 4'hA, 4'h5, 4'hF};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 4'h7, 4'h8, 4'h9, 4'h0, 4'h0, 4'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 4'hC, 4'h3, 4'h6, 4'hC, 4'h3, 4'h6};

        rst        = 1'b1;
        hsync_i    = 1'b0;
        vsync_i    = 1'b0;
        visible_i  = 1'b1;
        r_i        = 4'hF;
        g_i        = 4'hF;
        b_i        = 4'hF;
        frame_i    = 32'hFFFF_FFF0;
        fade_out_i = 1'b0;
        fade_in_i  = 1'b0;

        // Reset held 3 cycles with sync inputs active: outputs stay at idle/black.
        repeat (3) begin
            clk_cycle();
            check("rst_lat0", 32'({hsync0, vsync0, r0, g0, b0, level0}), 32'h6_0000);
            check("rst_lat3", 32'({hsync3, vsync3, r3, g3, b3, level3}), 32'h6_0000);
        end
        rst  = 1'b0;
        hist = '{3'b110, 3'b110, 3'b110};

        // Fade-in: 64 ticks (frame_i wraps on tick 16), then STEADY holds 16.
        ticks(1, 64, 1'b0);
        ticks(65, 68, 1'b0);

        // Table vectors at full level: exact passthrough, blanking, 2-cycle sync delay.
        foreach (vecs[i]) begin
            drive(vecs[i].hs, vecs[i].vs, vecs[i].vis, vecs[i].r, vecs[i].g, vecs[i].b,
                  1'b0, 1'b0, 1'b0, 16, {vecs[i].er, vecs[i].eg, vecs[i].eb});
        end

        // Fade-out from STEADY down to DARK, which then ignores ticks and fade_out_i.
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 16,
              pix_ref(1'b1, 4'hF, 4'hF, 4'hF, 16));
        ticks(1, 64, 1'b1);
        ticks(65, 70, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 0, 12'h000);

        // fade_in_i restarts from black.
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 0, 12'h000);
        ticks(1, 10, 1'b0);

        // Both pulses with a tick mid-step: fade_in_i wins and the tick is dropped.
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 0, 12'h000);
        ticks(1, 6, 1'b0);

        // fade_out_i with a tick at level 1, step 2: step restarts, so level 0 only on 4th tick.
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1,
              pix_ref(1'b1, 4'hF, 4'hF, 4'hF, 1));
        for (int n = 1; n <= 4; n++) begin
            drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, (n < 4) ? 1 : 0,
                  pix_ref(1'b1, 4'hF, 4'hF, 4'hF, (n < 4) ? 1 : 0));
        end

        // Back to full level, then varied sync/visible/colour to exercise lag-3 alignment.
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 0, 12'h000);
        ticks(1, 64, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic vis;
            vis = i[2] ^ i[0];
            drive(i[0], i[1], vis, 4'(i), 4'(~i), 4'(i + 3), 1'b0, 1'b0, 1'b0, 16,
                  pix_ref(vis, 4'(i), 4'(~i), 4'(i + 3), 16));
        end

        clk_cycle();
        clk_cycle();
        check("sb_drain", 32'(q0.size() + q3.size()), 32'd0);

        // Reset mid-stream: idle sync and black on the very next edge.
        rst       = 1'b1;
        hsync_i   = 1'b0;
        vsync_i   = 1'b0;
        visible_i = 1'b1;
        clk_cycle();
        check("midrst_lat0", 32'({hsync0, vsync0, r0, g0, b0, level0}), 32'h6_0000);
        check("midrst_lat3", 32'({hsync3, vsync3, r3, g3, b3, level3}), 32'h6_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
